// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared tag type and sizing constants for the unified memory port
package riscv_mem_pkg;
  typedef enum logic [1:0] {TAG_NONE, TAG_I, TAG_D} mem_tag_t;
  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_RD_LAT_MAX = 4;
endpackage

// File: rtl/mem_tag_pipe.sv
// mem_tag_pipe: RD_LAT-deep shift register tracking who owns each in-flight memory access
module mem_tag_pipe
  import riscv_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  mem_tag_t tag_in,
  output mem_tag_t tag_out
);
  mem_tag_t stage_q [RD_LAT];
  mem_tag_t stage_d [RD_LAT];
  // shift the new tag in at the head, every older tag moves one stage closer to the output
  always_comb begin
    stage_d[0] = tag_in;
    for (int k = 1; k < RD_LAT; k++) stage_d[k] = stage_q[k-1];
  end
  // reset discards every in-flight tag so no response can follow it
  always_ff @(posedge clk) begin
    for (int k = 0; k < RD_LAT; k++) stage_q[k] <= reset ? TAG_NONE : stage_d[k];
  end
  assign tag_out = stage_q[RD_LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined block RAM between fetch (I) and memory-access (D) stages
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall_f
);
  localparam logic [3:0] MAX_S = 4'(MAX_STARVE);
  logic [3:0]    starve_q, starve_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  mem_tag_t      tag_in, tag_out;
  // D wins unless fetch has been starved MAX_STARVE cycles in a row; nothing is granted in reset
  always_comb begin
    d_gnt    = ~reset & d_req & (~i_req | (starve_q < MAX_S));
    i_gnt    = ~reset & i_req & ~d_gnt;
    stall_f  = i_req & ~i_gnt;
    starve_d = (~i_req | i_gnt) ? 4'd0 : (starve_q == MAX_S) ? MAX_S : starve_q + 4'd1;
  end
  // drive the RAM from whichever side is granted and tag the access for its response
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_addr  = d_gnt ? d_addr : i_addr;
    mem_we    = (d_gnt & d_we) ? d_be : '0;
    mem_wdata = d_wdata;
    tag_in    = i_gnt ? TAG_I : (d_gnt & ~d_we) ? TAG_D : TAG_NONE;
  end
  mem_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );
  // returning word goes straight to its owner in the cycle it arrives and is held afterwards
  always_comb begin
    i_rvalid  = ~reset & (tag_out == TAG_I);
    d_rvalid  = ~reset & (tag_out == TAG_D);
    i_rdata   = reset ? '0 : i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata   = reset ? '0 : d_rvalid ? mem_rdata : d_rdata_q;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
  end
  // starvation counter and held response words
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the unified I/D memory arbiter
module tb_mem_port_arbiter;
  localparam int LAT  = 1;
  localparam int MAXS = 3;
  typedef struct {logic d; logic [31:0] data; int due;} rsp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, i_req, d_req, d_we, i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, stall_f;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  d_be, mem_we;
  logic        u3_reset, u3_i_req, u3_i_gnt, u3_i_rvalid, u3_d_gnt, u3_d_rvalid, u3_mem_en, u3_stall_f;
  logic [31:0] u3_i_addr, u3_i_rdata, u3_d_rdata, u3_mem_addr, u3_mem_wdata, u3_mem_rdata;
  logic [3:0]  u3_mem_we;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  rsp_t        sbq [$];
  int          compared = 0, mismatched = 0, cyc = 0, starve = 0;
  logic        e_ig, e_dg, e_iv, e_dv;
  logic [31:0] last_i, last_d;

  mem_port_arbiter #(.RD_LAT(LAT), .MAX_STARVE(MAXS)) u_dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .d_req(d_req), .d_we(d_we), .d_be(d_be),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f)
  );

  mem_port_arbiter #(.RD_LAT(3), .MAX_STARVE(MAXS)) u_dut3 (
    .clk(clk), .reset(u3_reset), .i_req(u3_i_req), .i_addr(u3_i_addr), .i_gnt(u3_i_gnt),
    .i_rvalid(u3_i_rvalid), .i_rdata(u3_i_rdata), .d_req(1'b0), .d_we(1'b0), .d_be(4'h0),
    .d_addr(32'h0), .d_wdata(32'h0), .d_gnt(u3_d_gnt), .d_rvalid(u3_d_rvalid), .d_rdata(u3_d_rdata),
    .mem_en(u3_mem_en), .mem_we(u3_mem_we), .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata),
    .mem_rdata(u3_mem_rdata), .stall_f(u3_stall_f)
  );

  function automatic logic [31:0] pat(int i);
    logic [7:0] b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'h3C};
  endfunction

  function automatic logic [31:0] pat3(logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) ram[mem_addr[9:2]][b*8+:8] <= mem_wdata[b*8+:8];
      mem_rdata <= ram[mem_addr[9:2]];
    end
    p0 <= pat3(u3_mem_addr);
    p1 <= p0;
    p2 <= p1;
  end
  assign u3_mem_rdata = p2;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        sbq.delete();
        starve = 0;
        last_i = '0;
        last_d = '0;
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
      end else begin
        e_dg = d_req && (!i_req || starve < MAXS);
        e_ig = i_req && !e_dg;
        check("i_gnt", i_gnt, e_ig);
        check("d_gnt", d_gnt, e_dg);
        check("stall_f", stall_f, i_req && !e_ig);
        check("mem_en", mem_en, e_ig || e_dg);
        check("mem_we", mem_we, (e_dg && d_we) ? d_be : 4'h0);
        if (e_ig || e_dg) check("mem_addr", mem_addr, e_dg ? d_addr : i_addr);
        if (e_dg && d_we) check("mem_wdata", mem_wdata, d_wdata);
        e_iv = sbq.size() > 0 && sbq[0].due == cyc && !sbq[0].d;
        e_dv = sbq.size() > 0 && sbq[0].due == cyc && sbq[0].d;
        if (e_iv) last_i = sbq[0].data;
        if (e_dv) last_d = sbq[0].data;
        if (e_iv || e_dv) void'(sbq.pop_front());
        check("i_rvalid", i_rvalid, e_iv);
        check("d_rvalid", d_rvalid, e_dv);
        check("i_rdata", i_rdata, last_i);
        check("d_rdata", d_rdata, last_d);
        if (e_ig) sbq.push_back('{1'b0, ref_mem[i_addr[9:2]], cyc + LAT});
        if (e_dg && d_we) begin
          for (int b = 0; b < 4; b++) if (d_be[b]) ref_mem[d_addr[9:2]][b*8+:8] = d_wdata[b*8+:8];
        end else if (e_dg) sbq.push_back('{1'b1, ref_mem[d_addr[9:2]], cyc + LAT});
        starve = (!i_req || e_ig) ? 0 : (starve < MAXS ? starve + 1 : starve);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = pat(i);
      ref_mem[i] = pat(i);
    end
    reset = 1; i_req = 1; d_req = 1; d_we = 0; d_be = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    u3_reset = 1; u3_i_req = 0; u3_i_addr = 0;
    repeat (3) step();
    reset = 0; d_req = 0; i_req = 1; i_addr = 0;
    step(); i_addr = 4;
    step(); i_addr = 8;
    step(); i_req = 0;
    step();
    i_req = 1; i_addr = 32'hC; d_req = 1; d_we = 0; d_addr = 32'h40;
    step(); d_req = 0;
    step(); i_req = 0;
    repeat (2) step();
    i_req = 1; d_req = 1; d_we = 0;
    for (int k = 0; k < 8; k++) begin
      d_addr = 32'h100 + 32'(4 * k);
      i_addr = 32'h200 + 32'(4 * k);
      step();
    end
    i_req = 0; d_req = 0;
    step();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
    step(); d_we = 0;
    step(); d_req = 0;
    repeat (2) step();
    for (int k = 0; k < 200; k++) begin
      reset   = (k == 100);
      i_req   = 1'($urandom_range(0, 1));
      d_req   = 1'($urandom_range(0, 1));
      d_we    = ($urandom_range(0, 3) == 0);
      d_be    = 4'($urandom_range(0, 15));
      i_addr  = $urandom & 32'h3FC;
      d_addr  = $urandom & 32'h3FC;
      d_wdata = $urandom;
      step();
    end
    reset = 0; i_req = 0; d_req = 0;
    repeat (5) step();
    check("sb_drain", sbq.size(), 0);
    u3_reset = 0;
    step();
    u3_i_req = 1; u3_i_addr = 32'h10;
    @(negedge clk);
    check("u3_gnt_a", u3_i_gnt, 1);
    step(); u3_i_req = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("u3_lat3_rvalid", u3_i_rvalid, k == 3);
      if (k == 3) check("u3_lat3_rdata", u3_i_rdata, pat3(32'h10));
    end
    step();
    u3_i_req = 1; u3_i_addr = 32'h20;
    @(negedge clk);
    check("u3_gnt_b", u3_i_gnt, 1);
    step(); u3_i_req = 0; u3_reset = 1;
    @(negedge clk);
    check("u3_rst_rvalid", u3_i_rvalid, 0);
    step(); u3_reset = 0;
    repeat (6) begin
      @(negedge clk);
      check("u3_no_rvalid", u3_i_rvalid, 0);
    end
    check("u3_rdata_cleared", u3_i_rdata, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
